// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the 4-way round-robin mux arbiter
package arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t PTR_RESET = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational winner selection; RR_MUX_ARB_FIXED_PRIO_EN selects lowest-index priority
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output req_idx_t         sel,
    output logic             any
);

`ifdef RR_MUX_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        sel = '0;
        any = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = req_idx_t'(i);
            end
        end
    end
`else
    // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1) so the nearest set request wins.
    always_comb begin
        req_idx_t idx;
        sel = '0;
        idx = '0;
        any = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ptr + req_idx_t'(k);
            if (req[idx]) begin
                sel = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// rtl/rr_mux_arbiter_4.sv - four requesters share a 4:1 mux and one registered valid/ready output; RR_MUX_ARB_FIXED_PRIO_EN selects fixed priority
module rr_mux_arbiter_4
    import arb_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [N_REQ-1:0]  ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output req_idx_t          out_src
);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    req_idx_t          src_q, src_d;
    logic [DATA_W-1:0] mux_data;
    req_idx_t          sel;
    req_idx_t          ptr;
    logic              any;
    logic              cap;

`ifdef RR_MUX_ARB_FIXED_PRIO_EN
    assign ptr = PTR_RESET;
`else
    req_idx_t ptr_q, ptr_d;

    assign ptr   = ptr_q;
    assign ptr_d = cap ? sel : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_RESET;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    rr_pick_4 u_pick (
        .req (req),
        .ptr (ptr),
        .sel (sel),
        .any (any)
    );

    always_comb begin
        mux_data = d0;
        case (sel)
            2'd0:    mux_data = d0;
            2'd1:    mux_data = d1;
            2'd2:    mux_data = d2;
            default: mux_data = d3;
        endcase
    end

    // A held word may be replaced in the same cycle it drains, giving back-to-back transfers.
    assign cap = any && ((state_q == ST_EMPTY) || out_ready);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        if (cap) begin
            state_d = ST_FULL;
            data_d  = mux_data;
            src_d   = sel;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign ack       = (cap && rst_n) ? (N_REQ'(1) << sel) : '0;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule
